// File: rtl/dual_port_mem_if.sv
// One memory port: byte address, write data/enable, byte-lane enables and combinational read data.
// The memory drives rdata and the client drives everything else.
interface dual_port_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wen;
  logic [NB-1:0]         ben;

  modport master (output addr, output wdata, output wen, output ben, input rdata);
  modport slave  (input addr, input wdata, input wen, input ben, output rdata);
endinterface

// File: rtl/dual_port_mem.sv
// Byte-addressed little-endian dual-port RAM with per-byte write enables and combinational reads.
// Both ports write on the rising edge; on a same-byte collision port b's data is kept.
module dual_port_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  dual_port_mem_if.slave port_a,
  dual_port_mem_if.slave port_b
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);

  logic [7:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic [ADDR_WIDTH-1:0] lane_addr_a [NB];
  logic [ADDR_WIDTH-1:0] lane_addr_b [NB];
  logic [NB-1:0]         wr_a;
  logic [NB-1:0]         wr_b;

  // Low address bits are dropped so an access never straddles or wraps past a word.
  always_comb begin
    base_a = port_a.addr & ~LANE_MASK;
    base_b = port_b.addr & ~LANE_MASK;
    wr_a   = port_a.wen ? port_a.ben : '0;
    wr_b   = port_b.wen ? port_b.ben : '0;
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_addr_a[gi] = base_a | ADDR_WIDTH'(gi);
      assign lane_addr_b[gi] = base_b | ADDR_WIDTH'(gi);
      assign port_a.rdata[8*gi +: 8] = rst ? 8'h00 : mem[lane_addr_a[gi]];
      assign port_b.rdata[8*gi +: 8] = rst ? 8'h00 : mem[lane_addr_b[gi]];
    end
  endgenerate

  // Port b is applied after port a so it overrides a write to the same byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_a[k]) begin
          mem[lane_addr_a[k]] <= port_a.wdata[8*k +: 8];
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (wr_b[k]) begin
          mem[lane_addr_b[k]] <= port_b.wdata[8*k +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_dual_port_mem.sv
// Self-checking bench for dual_port_mem: directed scenarios followed by random traffic on both
// ports, compared against a plain byte-array model of the memory.
module tb_dual_port_mem;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
  dual_port_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

  dual_port_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .port_a (a_if),
    .port_b (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [0:DEPTH-1];

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_base(input logic [AW-1:0] addr);
    return (int'(addr) / NB) * NB;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
    logic [31:0] r;
    int b;
    b = word_base(addr);
    for (int k = 0; k < NB; k++) r[8*k +: 8] = model[b + k];
    return r;
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] wdata,
                             input logic wen, input logic [NB-1:0] ben);
    int b;
    b = word_base(addr);
    if (wen) begin
      for (int k = 0; k < NB; k++) begin
        if (ben[k]) model[b + k] = wdata[8*k +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  task automatic drive_a(input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic wen, input logic [NB-1:0] ben);
    a_if.addr = addr; a_if.wdata = wdata; a_if.wen = wen; a_if.ben = ben;
  endtask

  task automatic drive_b(input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic wen, input logic [NB-1:0] ben);
    b_if.addr = addr; b_if.wdata = wdata; b_if.wen = wen; b_if.ben = ben;
  endtask

  // Inputs are already set while clk is low: check old data, clock, check new data.
  task automatic step(input string tag);
    #1;
    check({tag, "_pre_a"}, a_if.rdata, model_read(a_if.addr));
    check({tag, "_pre_b"}, b_if.rdata, model_read(b_if.addr));
    @(posedge clk);
    model_write(a_if.addr, a_if.wdata, a_if.wen, a_if.ben);
    model_write(b_if.addr, b_if.wdata, b_if.wen, b_if.ben);
    #1;
    check({tag, "_post_a"}, a_if.rdata, model_read(a_if.addr));
    check({tag, "_post_b"}, b_if.rdata, model_read(b_if.addr));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive_a('0, '0, 1'b0, '0);
    drive_b('0, '0, 1'b0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_rdata_a", a_if.rdata, 32'h0);
    check("reset_mem0", {24'h0, dut.mem[0]}, 32'h0);
    rst = 1'b0;

    // Reset clears written data and discards the write sampled on a reset edge.
    drive_a(16'h0100, 32'hDEADBEEF, 1'b1, 4'hF);
    step("wr_deadbeef");
    check("deadbeef_rd", a_if.rdata, 32'hDEADBEEF);
    drive_a(16'h0100, 32'h12345678, 1'b1, 4'hF);
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_async_rdata", a_if.rdata, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_rdata", a_if.rdata, 32'h0);
    for (int k = 0; k < NB; k++) check($sformatf("rst_mem_%0d", k), {24'h0, dut.mem[16'h0100 + k]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(16'h0100, 32'h0BADF00D, 1'b1, 4'hF);
    step("first_after_rst");
    check("first_after_rst_rd", a_if.rdata, 32'h0BADF00D);

    // Full-word write, readback on both ports.
    drive_a(16'h0040, 32'h11223344, 1'b1, 4'hF);
    drive_b(16'h0040, 32'h0, 1'b0, 4'h0);
    step("full_word");
    check("fw_mem40", {24'h0, dut.mem[16'h0040]}, 32'h44);
    check("fw_mem41", {24'h0, dut.mem[16'h0041]}, 32'h33);
    check("fw_mem42", {24'h0, dut.mem[16'h0042]}, 32'h22);
    check("fw_mem43", {24'h0, dut.mem[16'h0043]}, 32'h11);
    check("fw_rdata_b", b_if.rdata, 32'h11223344);

    // Byte enables, wen=0 and ben=0 no-ops.
    drive_a(16'h0080, 32'hAABBCCDD, 1'b1, 4'hF);
    step("preload");
    drive_a(16'h0080, 32'h55667788, 1'b0, 4'b0101);
    step("wen0");
    check("wen0_rd", a_if.rdata, 32'hAABBCCDD);
    drive_a(16'h0080, 32'h55667788, 1'b1, 4'b0000);
    step("ben0");
    check("ben0_rd", a_if.rdata, 32'hAABBCCDD);
    drive_a(16'h0080, 32'h55667788, 1'b1, 4'b0101);
    step("ben0101");
    check("ben0101_rd", a_if.rdata, 32'hAA66CC88);

    // Misaligned address lands on the word base.
    drive_a(16'h0083, 32'hCAFEF00D, 1'b1, 4'hF);
    step("misaligned");
    drive_a(16'h0000, 32'h0, 1'b0, 4'h0);
    drive_b(16'h0081, 32'h0, 1'b0, 4'h0);
    step("misaligned_rd");
    check("mis_rdata_b", b_if.rdata, 32'hCAFEF00D);
    check("mis_mem80", {24'h0, dut.mem[16'h0080]}, 32'h0D);

    // Top of memory does not wrap.
    drive_a(16'hFFFC, 32'h01020304, 1'b1, 4'hF);
    step("top");
    check("top_memffff", {24'h0, dut.mem[16'hFFFF]}, 32'h01);
    check("top_mem0000", {24'h0, dut.mem[16'h0000]}, 32'h00);

    // Same-edge writes: same byte (b wins) then distinct bytes.
    drive_a(16'h0010, 32'h000000AA, 1'b1, 4'b0001);
    drive_b(16'h0010, 32'h000000BB, 1'b1, 4'b0001);
    step("collide");
    check("collide_mem10", {24'h0, dut.mem[16'h0010]}, 32'hBB);
    drive_a(16'h0010, 32'h0000CC00, 1'b1, 4'b0010);
    drive_b(16'h0010, 32'h000000DD, 1'b1, 4'b0001);
    step("distinct");
    check("distinct_rd", a_if.rdata, 32'h0000CCDD);

    // Random traffic on a small window so the ports overlap often.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      rb = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      drive_a(ra, $urandom, 1'($urandom), 4'($urandom));
      drive_b(rb, $urandom, 1'($urandom), 4'($urandom));
      step($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_mem.md
Name: dual_port_mem

Overview:
- Byte-addressed, dual-port, little-endian RAM used as the data (and optionally instruction) memory in the core testbench.
- Port a normally serves the core's data interface. Port b is a second independent port; it is instruction fetch or tied off.
- Both ports write synchronously with per-byte enables and read combinationally.
- The byte array is named `mem`, so benches can access it hierarchically (`mem[i]`, one byte per entry).

Parameters:
- ADDR_WIDTH, 16, byte-address width. Capacity is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32, port data width. Must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.

Ports:
- clk  in  1  clock. All writes occur on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdata_a  out  DATA_WIDTH  port a read data (combinational).
- wdata_a  in  DATA_WIDTH  port a write data.
- addr_a  in  ADDR_WIDTH  port a byte address.
- wen_a  in  1  port a write enable.
- ben_a  in  NB  port a byte-lane enables. Bit k selects data bits [8k+7:8k].
- rdata_b  out  DATA_WIDTH  port b read data.
- wdata_b  in  DATA_WIDTH  port b write data.
- addr_b  in  ADDR_WIDTH  port b byte address.
- wen_b  in  1  port b write enable.
- ben_b  in  NB  port b byte-lane enables.

Behaviour:
- Storage: mem[0 .. 2**ADDR_WIDTH-1], 8 bits each. The array is visible hierarchically.
- Word base: base = addr with its log2(NB) LSBs forced to 0. Misaligned low bits are ignored, so accesses never straddle words or wrap.
- Read (per port):
  - Purely combinational, zero latency.
  - rdata[8k+7:8k] = mem[base+k] for k = 0..NB-1 (little-endian).
  - Read ignores wen and ben.
- Write (per port):
  - On posedge clk with rst low and wen=1, set mem[base+k] = wdata[8k+7:8k] for every k with ben[k]=1.
  - Bytes whose ben bit is 0 are unchanged.
  - wen=1 with ben=0 is a no-op.
  - wen=0 writes nothing, regardless of ben.
- Read-during-write, same port or cross-port:
  - Before the edge, rdata shows the old contents.
  - After the edge, rdata shows the new contents in the same delta-settled time step.
  - There is no write-first bypass.
- Simultaneous writes to the same byte from both ports on one edge: port b's value wins. Distinct bytes are written independently.
- Reset:
  - rst=1 asynchronously clears every byte to 0x00.
  - Reads return 0 while rst is held.
  - Writes are ignored while rst=1.
  - Reset asserted mid-operation discards any write sampled on that edge.
  - After rst falls, the first write occurs on the next rising edge with wen=1.
- Power-up contents before the first reset are unspecified (X allowed).
- Unused ports may be tied to 0: wen=0, ben=0, addr=0. Rdata may be left unconnected.

Test Plan:
- Reset clear: write 0xDEADBEEF at 0x0100 via port a, assert rst for 1 cycle -> rdata_a @0x0100 = 0x00000000 and mem[0x100..0x103] = 00.
- Full-word write/readback: port a writes 0x11223344 @0x0040 with ben=1111 -> mem[0x40]=44, mem[0x41]=33, mem[0x42]=22, mem[0x43]=11. Next cycle rdata_a = 0x11223344, and rdata_b @0x0040 matches.
- Byte enables: preload 0xAABBCCDD @0x0080, write 0x55667788 with ben=0101 -> rdata = 0xAA66CC88. The same write with wen=0 leaves 0xAABBCCDD.
- Misaligned address: write 0xCAFEF00D at addr 0x0083 -> it lands at base 0x0080, and a read at 0x0081 returns 0xCAFEF00D.
- Top of memory: write 0x01020304 @0xFFFC (ADDR_WIDTH=16) -> mem[0xFFFF]=01, mem[0x0000] is unchanged at 00.
- Port collision: same edge, port a writes 0x000000AA and port b writes 0x000000BB @0x0010 with ben=0001 -> mem[0x10]=BB. Port a ben=0010 / port b ben=0001 -> both bytes written.
